// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, PC source encodings and
// the instruction-fetch state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_NONE   = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of an instruction word into its MIPS fields, the
// sign-extended immediate and the J-type jump target.
module instr_field_split (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  functionCode,
  output logic [31:0] imm_sext,
  output logic [31:0] jump_target
);

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign shamt        = instr[10:6];
  assign functionCode = instr[5:0];
  assign imm_sext     = {{16{instr[15]}}, instr[15:0]};
  // pc here is already the incremented PC, as MIPS J-type expects.
  assign jump_target  = {pc[31:28], instr[25:0], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// PC + IR holder with a handshaked instruction-memory read and PC updates.
// Optional FETCH_TIMEOUT_EN aborts a fetch after TIMEOUT_CYCLES without mem_ack.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_err,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        alu_zero,
  input  logic [1:0]  pc_source,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  functionCode,
  output logic [31:0] imm_sext,
  output logic [31:0] jump_target
);

  fetch_state_e state, state_next;
  logic [31:0]  ir;
  logic [31:0]  pc_sel;
  logic         load_req;
  logic         aligned;
  logic         take_ack;
  logic         timeout_hit;
  logic         err_set;

  assign load_req = pc_write | (pc_write_cond & alu_zero);
  assign aligned  = (pc[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_REQ) wait_cnt <= '0;
    else if (!mem_ack)           wait_cnt <= wait_cnt + 1'b1;
  end

  // An ack on the final cycle still completes the fetch.
  assign timeout_hit = (state == S_REQ) && !mem_ack &&
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    take_ack   = 1'b0;
    case (state)
      S_IDLE: if (fetch_start && !load_req && aligned) state_next = S_REQ;
      S_REQ: begin
        if (mem_ack) begin
          take_ack   = 1'b1;
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_sel = pc;
    case (pc_src_e'(pc_source))
      PCSRC_ALU:    pc_sel = alu_result;
      PCSRC_ALUOUT: pc_sel = alu_out;
      PCSRC_JUMP:   pc_sel = jump_target;
      default:      pc_sel = pc;
    endcase
  end

  assign err_set = ((state == S_IDLE) && fetch_start && (load_req || !aligned)) ||
                   ((state != S_IDLE) && (pc_write || pc_write_cond)) ||
                   timeout_hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_next;
      if (err_set) fetch_err <= 1'b1;
      if (take_ack) begin
        ir <= mem_rdata;
        pc <= pc + 32'd4;
      end else if (state == S_IDLE && load_req) begin
        pc <= pc_sel;
      end
    end
  end

  assign mem_req     = (state == S_REQ);
  assign mem_addr    = pc;
  assign busy        = (state != S_IDLE);
  assign fetch_done  = (state == S_DONE);
  assign instruction = ir;

  instr_field_split u_split (
    .instr        (ir),
    .pc           (pc),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .functionCode (functionCode),
    .imm_sext     (imm_sext),
    .jump_target  (jump_target)
  );

endmodule
